// File: rtl/uart_rx_fifo.sv
// UART receiver with a 2-flop RX synchroniser and a mid-bit sampling FSM.
// Frames land in a small FIFO with per-entry parity/framing flags and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        RX,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        rdy,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [11:0]      HALF_DIV  = 12'(BAUD_DIV / 2);
    localparam logic [11:0]      FULL_DIV  = 12'(BAUD_DIV);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [11:0]            baud_q, baud_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   push;
    logic                   tick;
    logic [ENTRY_W-1:0]     push_entry;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   empty, full, do_pop, do_push, drop;
    logic [ENTRY_W-1:0]     head;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    // The down-counter lands on zero in this cycle: sample now and reload.
    assign tick = (baud_q == 12'd1);

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        push       = 1'b0;
        push_entry = {frm_err_q | ~rx_s_q, par_err_q, shift_q};

        if (state_q inside {START, DATA, PARITY, STOP}) begin
            baud_d = tick ? FULL_DIV : baud_q - 12'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    baud_d  = HALF_DIV;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    par_err_d = ((^shift_q) ^ rx_s_q) != ODD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    frm_err_d = frm_err_q | ~rx_s_q;
                    if (bit_idx_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = rx_s_q ? IDLE : BREAK;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_CNT);
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
        if (drop)         overrun_d = 1'b1;
        else if (clr_err) overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: storage is not reset; outputs are masked while empty, so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign rx_data    = empty ? '0 : head[DATA_BITS-1:0];
    assign parity_err = ~empty & head[DATA_BITS];
    assign frame_err  = ~empty & head[DATA_BITS+1];
    assign rdy        = ~empty;
    assign overrun    = overrun_q;
    assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three configurations (8N1, 8E1, 8N2) share one clock and reset.
// A queue-based model predicts the FIFO contents from the frames that were sent.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx, rd_en, clr_err;
    logic [7:0] rx_data [3];
    logic       pe      [3];
    logic       fe      [3];
    logic       rdy     [3];
    logic       ovr     [3];
    logic [2:0] cnt     [3];

    entry_t     model_q [3][$];
    logic [2:0] exp_ovr;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .clk(clk), .rst(rst), .RX(rx[0]), .rd_en(rd_en[0]), .clr_err(clr_err[0]),
        .rx_data(rx_data[0]), .parity_err(pe[0]), .frame_err(fe[0]), .rdy(rdy[0]),
        .overrun(ovr[0]), .fifo_cnt(cnt[0]));

    uart_rx_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
        .clk(clk), .rst(rst), .RX(rx[1]), .rd_en(rd_en[1]), .clr_err(clr_err[1]),
        .rx_data(rx_data[1]), .parity_err(pe[1]), .frame_err(fe[1]), .rdy(rdy[1]),
        .overrun(ovr[1]), .fifo_cnt(cnt[1]));

    uart_rx_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_8n2 (
        .clk(clk), .rst(rst), .RX(rx[2]), .rd_en(rd_en[2]), .clr_err(clr_err[2]),
        .rx_data(rx_data[2]), .parity_err(pe[2]), .frame_err(fe[2]), .rdy(rdy[2]),
        .overrun(ovr[2]), .fifo_cnt(cnt[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input int u, input string tag);
        entry_t head;
        int     sz;
        sz   = model_q[u].size();
        head = (sz != 0) ? model_q[u][0] : entry_t'(0);
        check({tag, ".cnt"},  32'(cnt[u]),     32'(sz));
        check({tag, ".rdy"},  32'(rdy[u]),     32'(sz != 0));
        check({tag, ".ovr"},  32'(ovr[u]),     32'(exp_ovr[u]));
        check({tag, ".data"}, 32'(rx_data[u]), 32'(head.data));
        check({tag, ".pe"},   32'(pe[u]),      32'(head.pe));
        check({tag, ".fe"},   32'(fe[u]),      32'(head.fe));
    endtask

    task automatic pop(input int u, input string tag);
        check_state(u, tag);
        rd_en[u] = 1'b1;
        @(posedge clk); #1;
        rd_en[u] = 1'b0;
        if (model_q[u].size() != 0) void'(model_q[u].pop_front());
    endtask

    task automatic clear_ovr(input int u);
        clr_err[u] = 1'b1;
        @(posedge clk); #1;
        clr_err[u] = 1'b0;
        exp_ovr[u] = 1'b0;
    endtask

    // side: 0 = nothing, 1 = rd_en on the push cycle, 2 = clr_err on the push cycle.
    // Unit 1 carries an even-parity bit; unit 2 has a fixed-high first stop bit.
    task automatic send_frame(input int u, input logic [7:0] d, input logic par_bit,
                              input logic stop_b, input int tail_low, input int side,
                              input string tag);
        logic [15:0] bits;
        int          n;
        int          push_edge;
        bit          was_empty;
        entry_t      e;
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        e = '0;
        e.data = d;
        if (u == 1) begin
            bits[n] = par_bit;
            n++;
            e.pe = ^{d, par_bit};
        end
        if (u == 2) n++;
        bits[n] = stop_b;
        n++;
        e.fe = ~stop_b;
        // 2 sync flops + 1 start-detect cycle, half a bit to the start sample, then whole bits.
        push_edge = 3 + BAUD / 2 + (n - 1) * BAUD;
        was_empty = (model_q[u].size() == 0);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    rx[u] = bits[i];
                    repeat (BAUD) @(posedge clk);
                    #1;
                end
                if (tail_low > 0) begin
                    repeat (tail_low) @(posedge clk);
                    #1;
                end
                rx[u] = 1'b1;
            end
            begin
                repeat (push_edge - 1) @(posedge clk);
                #1;
                if (side == 1) rd_en[u] = 1'b1;
                if (side == 2) clr_err[u] = 1'b1;
                if (side == 0 && was_empty) check({tag, ".rdy_early"}, 32'(rdy[u]), 32'd0);
                @(posedge clk); #1;
                rd_en[u]   = 1'b0;
                clr_err[u] = 1'b0;
                if (side == 0 && was_empty) check({tag, ".rdy_rise"}, 32'(rdy[u]), 32'd1);
            end
        join
        repeat (2 * BAUD) @(posedge clk);
        #1;
        if (side == 1) begin
            void'(model_q[u].pop_front());
            model_q[u].push_back(e);
        end else if (model_q[u].size() < DEPTH) begin
            model_q[u].push_back(e);
        end else begin
            exp_ovr[u] = 1'b1;
        end
        check_state(u, tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         u;
        logic [7:0] d;
        logic       pb, sb;

        rst = 1'b1;
        rx = 3'b111;
        rd_en = 3'b000;
        clr_err = 3'b000;
        exp_ovr = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) check_state(i, "reset");

        // Plain 8N1 frame, then pop it and pop once more while empty.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 0, "a5");
        pop(0, "a5_pop");
        pop(0, "empty_pop");
        check_state(0, "after_empty_pop");

        // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
        send_frame(1, 8'h07, 1'b1, 1'b1, 0, 0, "par_ok");
        send_frame(1, 8'h07, 1'b0, 1'b1, 0, 0, "par_bad");
        pop(1, "par_pop0");
        pop(1, "par_pop1");

        // Bad second stop bit, line then held low for 3 bit times.
        send_frame(2, 8'h3C, 1'b0, 1'b0, 3 * BAUD, 0, "break");
        pop(2, "break_pop");

        // Glitch shorter than half a bit must not be taken as a start bit.
        rx[0] = 1'b0;
        repeat (BAUD / 4) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (3 * BAUD) @(posedge clk);
        #1;
        check_state(0, "false_start");
        send_frame(0, 8'h33, 1'b0, 1'b1, 0, 0, "after_glitch");
        pop(0, "after_glitch_pop");

        // Overrun: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 0, 0, $sformatf("ovr_in%0d", i));
        for (int i = 1; i <= 4; i++) pop(0, $sformatf("ovr_out%0d", i));
        check_state(0, "ovr_drained");
        clear_ovr(0);
        check_state(0, "ovr_cleared");

        // Full FIFO with a pop on the push cycle, then a drop with clr_err on the same cycle.
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 0, 0, $sformatf("full_in%0d", i));
        send_frame(0, 8'h05, 1'b0, 1'b1, 0, 1, "full_push_pop");
        send_frame(0, 8'h66, 1'b0, 1'b1, 0, 2, "drop_vs_clr");
        for (int i = 0; i < 4; i++) pop(0, $sformatf("full_out%0d", i));
        clear_ovr(0);
        check_state(0, "full_cleared");

        // Reset in the middle of a data bit with one entry already queued.
        send_frame(0, 8'h11, 1'b0, 1'b1, 0, 0, "pre_rst");
        rx[0] = 1'b0;
        repeat (2 * BAUD) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (BAUD / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_q[i].delete();
        exp_ovr = 3'b000;
        check_state(0, "rst_mid");
        repeat (6 * BAUD) @(posedge clk);
        #1;
        check_state(0, "rst_idle");
        send_frame(0, 8'h5A, 1'b0, 1'b1, 0, 0, "post_rst");
        pop(0, "post_rst_pop");

        // Randomised frames across all three units with random reads and clears.
        for (int k = 0; k < 36; k++) begin
            u  = int'($urandom_range(0, 2));
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(u, d, pb, sb, 0, 0, $sformatf("rnd%0d_u%0d", k, u));
            while (model_q[u].size() != 0 && $urandom_range(0, 1) == 1)
                pop(u, $sformatf("rnd%0d_pop", k));
            if ($urandom_range(0, 5) == 0) begin
                clear_ovr(u);
                check_state(u, $sformatf("rnd%0d_clr", k));
            end
        end
        for (int i = 0; i < 3; i++) begin
            while (model_q[i].size() != 0) pop(i, $sformatf("drain_u%0d", i));
            check_state(i, $sformatf("drained_u%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
